tb_mem_latency_shim: RTL and testbench

//  Testbench memory-side stage between the AXI-to-memory bridge's req/we/addr/be/wdata port and the SRAM model.

---
 rtl/tb_mem_shim_pkg.sv | 21 ++
 rtl/tb_mem_shim_fifo.sv | 54 +++++
 rtl/tb_mem_latency_shim.sv | 169 ++++++++++++++++
 tb/tb_tb_mem_latency_shim.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_mem_shim_pkg.sv
// Shared types and constants for the testbench memory latency shim.
// The response beat type carries the write flag with the data so write beats
// can be forced to zero at the output.
package tb_mem_shim_pkg;

  localparam int RESP_DATA_W = 64;

  // Fibonacci LFSR: x^16 + x^14 + x^13 + x^11 + 1 -> taps on bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic                   is_write;
    logic [RESP_DATA_W-1:0] data;
  } resp_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tb_mem_shim_fifo.sv
// Show-ahead response FIFO: the head entry is presented on pop_data whenever
// the FIFO is non-empty. Pointers wrap modulo DEPTH (power of two).
module tb_mem_shim_fifo
  import tb_mem_shim_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             pop_ok;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push and pop keeps count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage is data only and is never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tb_mem_latency_shim.sv
// Memory-side latency shim between the AXI-to-memory bridge and the SRAM model.
// Adds req/gnt and rvalid/rready handshakes, a fixed grant-to-response latency
// and a credit limit of RESP_DEPTH outstanding requests. Responses return in
// grant order; write beats return rdata_o = '0.
// Optional feature macro: TB_MEM_SHIM_RANDOM_STALL_EN (LFSR-driven grant
// stalls and 0..3 extra cycles of response visibility delay).
module tb_mem_latency_shim
  import tb_mem_shim_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int LATENCY    = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int              CW      = $clog2(RESP_DEPTH) + 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(RESP_DEPTH);

  logic [CW-1:0] cnt_q;
  logic          stall;
  logic          grant;
  logic          pop;
  logic          head_visible;
  logic          vld_p0;
  logic          we_p0;
  resp_t         resp_p0;
  logic          push_vld;
  resp_t         push_resp;
  resp_t         head;
  logic          fifo_full;
  logic          fifo_empty;

  // Grant uses only registered credit/stall state plus req_i, never rready_i
  assign grant       = req_i & ~rst_i & (cnt_q < CNT_MAX) & ~stall;
  assign gnt_o       = grant;
  assign pop         = rvalid_o & rready_i;

  assign mem_req_o   = req_i & gnt_o;
  assign mem_we_o    = we_i;
  assign mem_addr_o  = addr_i;
  assign mem_be_o    = be_i;
  assign mem_wdata_o = wdata_i;

  assign rvalid_o    = ~fifo_empty & head_visible;
  assign rdata_o     = (rvalid_o & ~head.is_write) ? DATA_WIDTH'(head.data) : '0;

  // Credit counter: granted minus popped; grant and pop together cancel
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      case ({grant, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  // ---- stage p0: grant cycle + 1, SRAM read data valid on mem_rdata_i ----
  // Control bit of the first stage
  always_ff @(posedge clk_i) begin
    if (rst_i) vld_p0 <= 1'b0;
    else       vld_p0 <= grant;
  end

  // Direction of the granted request, carried alongside vld_p0
  always_ff @(posedge clk_i) begin
    we_p0 <= we_i;
  end

  assign resp_p0.is_write = we_p0;
  assign resp_p0.data     = we_p0 ? '0 : RESP_DATA_W'(mem_rdata_i);

  // ---- stages p1..: pad out to LATENCY cycles before the FIFO write ----
  if (LATENCY == 2) begin : g_no_delay
    assign push_vld  = vld_p0;
    assign push_resp = resp_p0;
  end else begin : g_delay
    localparam int N = LATENCY - 2;
    logic  vld_pn  [N];
    resp_t resp_pn [N];

    // Valid shift chain, cleared on reset to drop in-flight responses
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < N; i++) vld_pn[i] <= 1'b0;
      end else begin
        vld_pn[0] <= vld_p0;
        for (int i = 1; i < N; i++) vld_pn[i] <= vld_pn[i-1];
      end
    end

    // Data shift chain, follows the valid chain without reset
    always_ff @(posedge clk_i) begin
      resp_pn[0] <= resp_p0;
      for (int i = 1; i < N; i++) resp_pn[i] <= resp_pn[i-1];
    end

    assign push_vld  = vld_pn[N-1];
    assign push_resp = resp_pn[N-1];
  end

  // ---- FIFO write: entry visible at grant cycle + LATENCY ----
  tb_mem_shim_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH ($bits(resp_t))
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push_vld),
    .push_data (push_resp),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Credits bound occupancy, so a push into a full FIFO needs a same-cycle pop
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(push_vld && fifo_full && !pop));
  end

`ifdef TB_MEM_SHIM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic [1:0]  hold_q;
  logic        fresh_head;

  // Free-running LFSR, restarts from the seed on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign stall      = (lfsr_q[1:0] == 2'b00);
  assign fresh_head = pop | (fifo_empty & push_vld);

  // Each new FIFO head waits 0..3 extra cycles before it becomes visible
  always_ff @(posedge clk_i) begin
    if (rst_i)              hold_q <= 2'd0;
    else if (fresh_head)    hold_q <= lfsr_q[3:2];
    else if (hold_q != 2'd0) hold_q <= hold_q - 2'd1;
  end

  assign head_visible = (hold_q == 2'd0);
`else
  assign stall        = 1'b0;
  assign head_visible = 1'b1;
`endif

endmodule

// File: tb/tb_tb_mem_latency_shim.sv
// Directed self-checking bench for tb_mem_latency_shim with a byte-enabled SRAM
// model that returns read data one cycle after the strobe.
module tb_tb_mem_latency_shim;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic        we;
  logic [63:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tb_mem_latency_shim #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (64),
    .LATENCY    (4),
    .RESP_DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_o       (gnt),
    .we_i        (we),
    .addr_i      (addr),
    .be_i        (be),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .rdata_o     (rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_be_o    (mem_be),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Power-up contents: 0x40 holds DEADBEEF, 0x100 and above hold a tagged address
  function automatic logic [63:0] init_word(input logic [63:0] a);
    if (a == 64'h40)   return 64'h0000_0000_DEAD_BEEF;
    if (a >= 64'h100)  return {32'hA5A5_0000, a[31:0]};
    return 64'h0;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] base, input logic [63:0] d,
                                        input logic [7:0] en);
    logic [63:0] r;
    r = base;
    for (int b = 0; b < 8; b++) if (en[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  logic [63:0] sram     [512];
  bit          sram_vld [512];
  logic [8:0]  sidx;
  assign sidx = mem_addr[11:3];

  // SRAM model: one-cycle read latency; write cycles leave junk on the read bus
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        sram[sidx]     <= merge(sram_vld[sidx] ? sram[sidx] : init_word(mem_addr),
                                mem_wdata, mem_be);
        sram_vld[sidx] <= 1'b1;
        mem_rdata      <= 64'hBAD0_BAD0_BAD0_BAD0;
      end else begin
        mem_rdata <= sram_vld[sidx] ? sram[sidx] : init_word(mem_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [63:0] shadow     [512];
  bit          shadow_vld [512];

  initial begin
    int          issued;
    int          rcnt;
    logic [12:0] exp_gnt;
    logic [12:0] exp_rv;
    logic [63:0] held;
    int          nrand;
    int          sent;
    int          got;
    int          cyc;
    int          stalled;
    logic        pending;
    logic        p_we;
    logic [63:0] p_addr;
    logic [63:0] p_data;
    logic [63:0] q [$];
    logic [63:0] e;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = 8'hFF; wdata = '0; rready = 1'b1;
    tick();
    tick();
    // Reset state, with a request pending during reset
    req = 1'b1;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    tick();
    rst = 1'b0; req = 1'b0;
    #1;
    chk("idle_rvalid", 64'(rvalid), 64'd0);
    tick();

`ifndef TB_MEM_SHIM_RANDOM_STALL_EN
    // Single read of 0x40: grant at t, response at t+4
    req = 1'b1; we = 1'b0; addr = 64'h40;
    #1;
    chk("t1_gnt", 64'(gnt), 64'd1);
    chk("t1_mem_req", 64'(mem_req), 64'd1);
    chk("t1_mem_addr", mem_addr, 64'h40);
    tick();
    req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("t1_early_rvalid%0d", k), 64'(rvalid), 64'd0);
      tick();
    end
    #1;
    chk("t1_rvalid", 64'(rvalid), 64'd1);
    chk("t1_rdata", rdata, 64'h0000_0000_DEAD_BEEF);
    tick();
    #1;
    chk("t1_rvalid_after", 64'(rvalid), 64'd0);
    tick();

    // Burst of 8 reads with rready high: credits stall the 5th grant one cycle
    exp_gnt = 13'h01EF;
    exp_rv  = 13'h1EF0;
    issued  = 0;
    rcnt    = 0;
    for (int c = 0; c < 13; c++) begin
      req  = (issued < 8);
      addr = 64'h100 + 64'(8 * issued);
      #1;
      chk($sformatf("t2_gnt_c%0d", c), 64'(gnt), 64'(exp_gnt[c]));
      chk($sformatf("t2_rvalid_c%0d", c), 64'(rvalid), 64'(exp_rv[c]));
      if (rvalid) begin
        chk($sformatf("t2_rdata%0d", rcnt), rdata, init_word(64'h100 + 64'(8 * rcnt)));
        rcnt++;
      end
      if (gnt) issued++;
      tick();
    end
    req = 1'b0;
    #1;
    chk("t2_issued", 64'(issued), 64'd8);
    chk("t2_received", 64'(rcnt), 64'd8);
    chk("t2_rvalid_end", 64'(rvalid), 64'd0);
    tick();

    // Backpressure: rready low for 20 cycles
    rready = 1'b0;
    issued = 0;
    held   = '0;
    for (int c = 0; c < 20; c++) begin
      req  = 1'b1;
      addr = 64'h180 + 64'(8 * issued);
      #1;
      if (c == 4) held = rdata;
      if (c == 19) begin
        chk("t3_gnt_blocked", 64'(gnt), 64'd0);
        chk("t3_rvalid_held", 64'(rvalid), 64'd1);
        chk("t3_rdata_stable", rdata, held);
        chk("t3_rdata_head", rdata, init_word(64'h180));
      end
      if (gnt) issued++;
      tick();
    end
    chk("t3_grants", 64'(issued), 64'd4);
    req = 1'b0; rready = 1'b1;
    rcnt = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rvalid) begin
        chk($sformatf("t3_drain%0d", rcnt), rdata, init_word(64'h180 + 64'(8 * rcnt)));
        rcnt++;
      end
      tick();
    end
    chk("t3_drained", 64'(rcnt), 64'd4);

    // Partial write then read back
    req = 1'b1; we = 1'b1; addr = 64'h80; be = 8'h0F; wdata = 64'h1122_3344_5566_7788;
    #1;
    chk("t4_wr_gnt", 64'(gnt), 64'd1);
    chk("t4_mem_we", 64'(mem_we), 64'd1);
    chk("t4_mem_be", 64'(mem_be), 64'h0F);
    chk("t4_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    tick();
    req = 1'b0; we = 1'b0; be = 8'hFF; wdata = '0;
    tick(); tick(); tick();
    #1;
    chk("t4_wr_rvalid", 64'(rvalid), 64'd1);
    chk("t4_wr_rdata", rdata, 64'd0);
    tick();
    req = 1'b1; addr = 64'h80;
    #1;
    chk("t4_rd_gnt", 64'(gnt), 64'd1);
    tick();
    req = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("t4_rd_rvalid", 64'(rvalid), 64'd1);
    chk("t4_rd_rdata", rdata, 64'h0000_0000_5566_7788);
    tick();

    // Reset with three reads in flight
    for (int c = 0; c < 3; c++) begin
      req = 1'b1; addr = 64'h100 + 64'(8 * c);
      #1;
      chk($sformatf("t5_gnt%0d", c), 64'(gnt), 64'd1);
      tick();
    end
    rst = 1'b1; addr = 64'h118;
    #1;
    chk("t5_gnt_in_rst", 64'(gnt), 64'd0);
    tick();
    rst = 1'b0; req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t5_dropped%0d", c), 64'(rvalid), 64'd0);
      tick();
    end
    rready = 1'b0;
    issued = 0;
    for (int c = 0; c < 6; c++) begin
      req  = 1'b1;
      addr = 64'h120 + 64'(8 * issued);
      #1;
      if (c == 4) begin
        chk("t5_first_rvalid", 64'(rvalid), 64'd1);
        chk("t5_first_rdata", rdata, init_word(64'h120));
      end
      if (gnt) issued++;
      tick();
    end
    chk("t5_grants_after_rst", 64'(issued), 64'd4);
    req = 1'b0; rready = 1'b1;
    rcnt = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rvalid) begin
        chk($sformatf("t5_drain%0d", rcnt), rdata, init_word(64'h120 + 64'(8 * rcnt)));
        rcnt++;
      end
      tick();
    end
    chk("t5_drained", 64'(rcnt), 64'd4);
`endif

    // Random traffic against a shadow memory, random rready
`ifdef TB_MEM_SHIM_RANDOM_STALL_EN
    nrand = 1000;
`else
    nrand = 200;
`endif
    sent = 0; got = 0; cyc = 0; stalled = 0; pending = 1'b0;
    p_we = 1'b0; p_addr = 64'h100; p_data = '0;
    be = 8'hFF;
    while (got < nrand && cyc < 20000) begin
      if (!pending && sent < nrand && $urandom_range(3) != 0) begin
        pending = 1'b1;
        p_we    = ($urandom_range(3) == 0);
        p_addr  = p_we ? 64'h200 + 64'(8 * $urandom_range(31))
                       : 64'h100 + 64'(8 * $urandom_range(63));
        p_data  = {$urandom, $urandom};
      end
      req = pending; we = p_we; addr = p_addr; wdata = p_data;
      rready = 1'($urandom_range(1));
      #1;
      if (req && !gnt) stalled++;
      if (gnt) begin
        sent++;
        pending = 1'b0;
        if (p_we) begin
          q.push_back(64'd0);
          shadow[p_addr[11:3]]     = p_data;
          shadow_vld[p_addr[11:3]] = 1'b1;
        end else begin
          q.push_back(shadow_vld[p_addr[11:3]] ? shadow[p_addr[11:3]] : init_word(p_addr));
        end
      end
      if (rvalid && rready) begin
        if (q.size() == 0) begin
          chk("rand_extra_beat", 64'(got), 64'(sent));
        end else begin
          e = q.pop_front();
          chk($sformatf("rand_beat%0d", got), rdata, e);
        end
        got++;
      end
      tick();
      cyc++;
    end
    req = 1'b0; rready = 1'b1;
    chk("rand_received", 64'(got), 64'(nrand));
    chk("rand_outstanding", 64'(q.size()), 64'd0);
`ifdef TB_MEM_SHIM_RANDOM_STALL_EN
    chk("rand_gnt_duty_below_full", 64'(stalled > 0), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
